// File: rtl/toy_pack.sv
// Shared sizing constants and the writeback entry type for the toy core's
// writeback path.
package toy_pack;

    localparam int EU_NUM           = 4;
    localparam int WB_PORT_NUM      = 2;
    localparam int REG_WIDTH        = 32;
    localparam int PHY_REG_ID_WIDTH = 7;
    localparam int EU_ID_WIDTH      = $clog2(EU_NUM);
    localparam int WB_FIFO_DEPTH    = 2;

    typedef struct packed {
        logic [PHY_REG_ID_WIDTH-1:0] idx;
        logic [REG_WIDTH-1:0]        data;
    } wb_entry_t;

endpackage

// File: rtl/toy_wb_fifo.sv
// Small synchronous FIFO of writeback entries, one per execution unit.
// DEPTH must be a power of two so the pointers wrap naturally.
module toy_wb_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The caller never pushes when full nor pops when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/toy_wb_arbiter.sv
// Writeback arbiter: per-EU result FIFOs, round-robin grant of the register
// file write ports. Define TOY_WB_BYPASS_EN to let an empty FIFO's input bid directly.
module toy_wb_arbiter
    import toy_pack::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [EU_NUM-1:0]           v_eu_wb_vld,
    output logic [EU_NUM-1:0]           v_eu_wb_rdy,
    input  logic [PHY_REG_ID_WIDTH-1:0] v_eu_wb_idx    [EU_NUM],
    input  logic [REG_WIDTH-1:0]        v_eu_wb_data   [EU_NUM],
    output logic [WB_PORT_NUM-1:0]      v_wr_port_en,
    output logic [PHY_REG_ID_WIDTH-1:0] v_wr_port_idx  [WB_PORT_NUM],
    output logic [REG_WIDTH-1:0]        v_wr_port_data [WB_PORT_NUM],
    output logic [EU_NUM-1:0]           v_wr_reg_vld,
    output logic [REG_WIDTH-1:0]        v_wr_reg_data  [EU_NUM]
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t              in_entry   [EU_NUM];
    wb_entry_t              fifo_head  [EU_NUM];
    wb_entry_t              cand_entry [EU_NUM];
    logic [CNT_W-1:0]       fifo_count [EU_NUM];
    logic [EU_NUM-1:0]      fifo_full;
    logic [EU_NUM-1:0]      fifo_empty;
    logic [EU_NUM-1:0]      fifo_push;
    logic [EU_NUM-1:0]      fifo_pop;
    logic [EU_NUM-1:0]      cand_vld;
    logic [EU_NUM-1:0]      eu_grant;
    logic [EU_NUM-1:0]      eu_take;
    logic [WB_PORT_NUM-1:0] grant_port_en;
    logic [EU_ID_WIDTH-1:0] grant_port_eu [WB_PORT_NUM];
    logic [EU_ID_WIDTH-1:0] rr_ptr;
    logic [EU_ID_WIDTH-1:0] rr_next;
    logic [EU_ID_WIDTH-1:0] scan_eu;
    logic [EU_ID_WIDTH-1:0] last_eu;
    int                     used_ports;

    for (genvar g = 0; g < EU_NUM; g++) begin : g_fifo
        toy_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (fifo_push[g]),
            .push_entry (in_entry[g]),
            .pop        (fifo_pop[g]),
            .head       (fifo_head[g]),
            .count      (fifo_count[g]),
            .full       (fifo_full[g])
        );
        assign fifo_empty[g]  = (fifo_count[g] == '0);
        assign v_eu_wb_rdy[g] = rst_n & ~fifo_full[g];
    end

    // Each EU bids with its FIFO head, or with its raw input when bypass is
    // built in and nothing is queued ahead of it.
    always_comb begin
        for (int i = 0; i < EU_NUM; i++) begin
            in_entry[i] = '{idx: v_eu_wb_idx[i], data: v_eu_wb_data[i]};
`ifdef TOY_WB_BYPASS_EN
            cand_vld[i]   = ~fifo_empty[i] | v_eu_wb_vld[i];
            cand_entry[i] = fifo_empty[i] ? in_entry[i] : fifo_head[i];
`else
            cand_vld[i]   = ~fifo_empty[i];
            cand_entry[i] = fifo_head[i];
`endif
        end
    end

    // Zero-index results are dropped wherever they sit in the scan, so they
    // never hold up the EU behind them or use up a port.
    always_comb begin
        eu_grant      = '0;
        eu_take       = '0;
        grant_port_en = '0;
        for (int p = 0; p < WB_PORT_NUM; p++) begin
            grant_port_eu[p] = '0;
        end
        used_ports = 0;
        last_eu    = '0;
        scan_eu    = '0;
        for (int k = 0; k < EU_NUM; k++) begin
            scan_eu = EU_ID_WIDTH'((int'(rr_ptr) + k) % EU_NUM);
            if (cand_vld[scan_eu]) begin
                if (cand_entry[scan_eu].idx == '0) begin
                    eu_take[scan_eu] = 1'b1;
                end else if (used_ports < WB_PORT_NUM) begin
                    eu_grant[scan_eu]         = 1'b1;
                    eu_take[scan_eu]          = 1'b1;
                    grant_port_en[used_ports] = 1'b1;
                    grant_port_eu[used_ports] = scan_eu;
                    used_ports                = used_ports + 1;
                    last_eu                   = scan_eu;
                end
            end
        end
        rr_next = grant_port_en[0] ? EU_ID_WIDTH'((int'(last_eu) + 1) % EU_NUM) : rr_ptr;
    end

    // An input consumed straight from the bypass path is never queued.
    always_comb begin
        for (int i = 0; i < EU_NUM; i++) begin
            fifo_pop[i]  = eu_take[i] & ~fifo_empty[i];
            fifo_push[i] = v_eu_wb_vld[i] & v_eu_wb_rdy[i] & ~(eu_take[i] & fifo_empty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // Idle ports and EUs keep their last data so the forward stage sees stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_wr_port_en <= '0;
            v_wr_reg_vld <= '0;
            for (int p = 0; p < WB_PORT_NUM; p++) begin
                v_wr_port_idx[p]  <= '0;
                v_wr_port_data[p] <= '0;
            end
            for (int i = 0; i < EU_NUM; i++) begin
                v_wr_reg_data[i] <= '0;
            end
        end else begin
            v_wr_port_en <= grant_port_en;
            v_wr_reg_vld <= eu_grant;
            for (int p = 0; p < WB_PORT_NUM; p++) begin
                if (grant_port_en[p]) begin
                    v_wr_port_idx[p]  <= cand_entry[grant_port_eu[p]].idx;
                    v_wr_port_data[p] <= cand_entry[grant_port_eu[p]].data;
                end
            end
            for (int i = 0; i < EU_NUM; i++) begin
                if (eu_grant[i]) begin
                    v_wr_reg_data[i] <= cand_entry[i].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_toy_wb_arbiter.sv
// Self-checking bench for toy_wb_arbiter (default build, no bypass):
// directed vector table, reset sequence and a scoreboarded random soak.
module tb_toy_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  eu_vld;
    logic [3:0]  eu_rdy;
    logic [6:0]  eu_idx   [4];
    logic [31:0] eu_data  [4];
    logic [1:0]  wr_en;
    logic [6:0]  wr_idx   [2];
    logic [31:0] wr_data  [2];
    logic [3:0]  reg_vld;
    logic [31:0] reg_data [4];

    int total_checks  = 0;
    int passed_checks = 0;
    int seq_no        = 0;
    int occ   [4];
    int waits [4];
    logic [31:0] expq [4][$];

    always #5 clk = ~clk;

    toy_wb_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .v_eu_wb_vld    (eu_vld),
        .v_eu_wb_rdy    (eu_rdy),
        .v_eu_wb_idx    (eu_idx),
        .v_eu_wb_data   (eu_data),
        .v_wr_port_en   (wr_en),
        .v_wr_port_idx  (wr_idx),
        .v_wr_port_data (wr_data),
        .v_wr_reg_vld   (reg_vld),
        .v_wr_reg_data  (reg_data)
    );

    // Packed fields are ordered {EU3,EU2,EU1,EU0} and {port1,port0}.
    typedef struct {
        logic [3:0]       vld;
        logic [3:0][6:0]  idx;
        logic [3:0][31:0] data;
        logic [1:0]       en;
        logic [1:0][6:0]  pidx;
        logic [1:0][31:0] pdata;
        logic [3:0]       rvld;
        logic [3:0][31:0] rdata;
        logic [3:0]       rdy;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic [3:0] vld, logic [27:0] idx, logic [127:0] data,
                                logic [1:0] en, logic [13:0] pidx, logic [63:0] pdata,
                                logic [3:0] rvld, logic [127:0] rdata, logic [3:0] rdy);
        vec_t v;
        v.vld = vld;  v.idx = idx;   v.data = data;
        v.en  = en;   v.pidx = pidx; v.pdata = pdata;
        v.rvld = rvld; v.rdata = rdata; v.rdy = rdy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        eu_vld = v.vld;
        for (int i = 0; i < 4; i++) begin
            eu_idx[i]  = v.idx[i];
            eu_data[i] = v.data[i];
        end
    endtask

    task automatic setIdle();
        eu_vld = '0;
        for (int i = 0; i < 4; i++) begin
            eu_idx[i]  = '0;
            eu_data[i] = '0;
        end
    endtask

    // One random (or idle) cycle against the per-EU occupancy and order model.
    task automatic soakCycle(input bit drive);
        logic [3:0] pushed;
        for (int i = 0; i < 4; i++) begin
            if (drive) begin
                eu_vld[i]  = 1'($urandom_range(0, 1));
                eu_idx[i]  = 7'($urandom_range(1, 127));
                eu_data[i] = {2'(i), 30'(seq_no)};
                seq_no++;
            end else begin
                eu_vld[i] = 1'b0;
            end
            checkOutput($sformatf("soak_rdy%0d", i), 32'(eu_rdy[i]), 32'(occ[i] < 2));
            pushed[i] = eu_vld[i] && (occ[i] < 2);
            if (pushed[i]) expq[i].push_back(eu_data[i]);
        end
        @(posedge clk);
        #1;
        checkOutput("soak_ports", 32'($countones(wr_en)), 32'($countones(reg_vld)));
        for (int i = 0; i < 4; i++) begin
            if (occ[i] > 0) begin
                waits[i] = reg_vld[i] ? 0 : waits[i] + 1;
                checkOutput($sformatf("soak_fair%0d", i), 32'(waits[i] <= 1), 32'd1);
            end
            if (reg_vld[i]) begin
                if (expq[i].size() == 0) begin
                    checkOutput($sformatf("soak_extra%0d", i), 32'(expq[i].size()), 32'd1);
                end else begin
                    checkOutput($sformatf("soak_data%0d", i), reg_data[i], expq[i].pop_front());
                end
            end
            occ[i] = occ[i] + int'(pushed[i]) - int'(reg_vld[i]);
        end
    endtask

    initial begin
        // Directed vectors: inputs applied for one cycle, registered outputs and rdy
        // sampled just after the edge closing that cycle.
        vecs[0]  = mk(4'b0001, {7'd0,7'd0,7'd0,7'd5}, {32'h0,32'h0,32'h0,32'hDEADBEEF},
                      2'b00, {7'd0,7'd0}, {32'h0,32'h0}, 4'b0000, {32'h0,32'h0,32'h0,32'h0}, 4'b1111);
        vecs[1]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b01, {7'd0,7'd5}, {32'h0,32'hDEADBEEF}, 4'b0001, {32'h0,32'h0,32'h0,32'hDEADBEEF}, 4'b1111);
        vecs[2]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b00, {7'd0,7'd5}, {32'h0,32'hDEADBEEF}, 4'b0000, {32'h0,32'h0,32'h0,32'hDEADBEEF}, 4'b1111);
        vecs[3]  = mk(4'b1000, {7'd3,7'd0,7'd0,7'd0}, {32'h33,32'h0,32'h0,32'h0},
                      2'b00, {7'd0,7'd5}, {32'h0,32'hDEADBEEF}, 4'b0000, {32'h0,32'h0,32'h0,32'hDEADBEEF}, 4'b1111);
        vecs[4]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b01, {7'd0,7'd3}, {32'h0,32'h33}, 4'b1000, {32'h33,32'h0,32'h0,32'hDEADBEEF}, 4'b1111);
        vecs[5]  = mk(4'b1111, {7'd13,7'd12,7'd11,7'd10}, {32'hA3,32'hA2,32'hA1,32'hA0},
                      2'b00, {7'd0,7'd3}, {32'h0,32'h33}, 4'b0000, {32'h33,32'h0,32'h0,32'hDEADBEEF}, 4'b1111);
        vecs[6]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b11, {7'd11,7'd10}, {32'hA1,32'hA0}, 4'b0011, {32'h33,32'h0,32'hA1,32'hA0}, 4'b1111);
        vecs[7]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b11, {7'd13,7'd12}, {32'hA3,32'hA2}, 4'b1100, {32'hA3,32'hA2,32'hA1,32'hA0}, 4'b1111);
        vecs[8]  = mk(4'b0000, 28'h0, 128'h0,
                      2'b00, {7'd13,7'd12}, {32'hA3,32'hA2}, 4'b0000, {32'hA3,32'hA2,32'hA1,32'hA0}, 4'b1111);
        vecs[9]  = mk(4'b0110, {7'd0,7'd9,7'd0,7'd0}, {32'h0,32'h99,32'h55,32'h0},
                      2'b00, {7'd13,7'd12}, {32'hA3,32'hA2}, 4'b0000, {32'hA3,32'hA2,32'hA1,32'hA0}, 4'b1111);
        vecs[10] = mk(4'b0000, 28'h0, 128'h0,
                      2'b01, {7'd13,7'd9}, {32'hA3,32'h99}, 4'b0100, {32'hA3,32'h99,32'hA1,32'hA0}, 4'b1111);
        vecs[11] = mk(4'b1001, {7'd23,7'd0,7'd0,7'd20}, {32'hC3,32'h0,32'h0,32'hC0},
                      2'b00, {7'd13,7'd9}, {32'hA3,32'h99}, 4'b0000, {32'hA3,32'h99,32'hA1,32'hA0}, 4'b1111);
        vecs[12] = mk(4'b0000, 28'h0, 128'h0,
                      2'b11, {7'd20,7'd23}, {32'hC0,32'hC3}, 4'b1001, {32'hC3,32'h99,32'hA1,32'hC0}, 4'b1111);
        vecs[13] = mk(4'b1111, {7'd40,7'd32,7'd31,7'd30}, {32'hE0,32'hD2,32'hD1,32'hD0},
                      2'b00, {7'd20,7'd23}, {32'hC0,32'hC3}, 4'b0000, {32'hC3,32'h99,32'hA1,32'hC0}, 4'b1111);
        vecs[14] = mk(4'b1111, {7'd41,7'd32,7'd31,7'd30}, {32'hE1,32'hD6,32'hD5,32'hD4},
                      2'b11, {7'd32,7'd31}, {32'hD2,32'hD1}, 4'b0110, {32'hC3,32'hD2,32'hD1,32'hC0}, 4'b0110);
        vecs[15] = mk(4'b1000, {7'd42,7'd0,7'd0,7'd0}, {32'hE2,32'h0,32'h0,32'h0},
                      2'b11, {7'd30,7'd40}, {32'hD0,32'hE0}, 4'b1001, {32'hE0,32'hD2,32'hD1,32'hD0}, 4'b1111);
        vecs[16] = mk(4'b1000, {7'd42,7'd0,7'd0,7'd0}, {32'hE2,32'h0,32'h0,32'h0},
                      2'b11, {7'd32,7'd31}, {32'hD6,32'hD5}, 4'b0110, {32'hE0,32'hD6,32'hD5,32'hD0}, 4'b0111);
        vecs[17] = mk(4'b0000, 28'h0, 128'h0,
                      2'b11, {7'd30,7'd41}, {32'hD4,32'hE1}, 4'b1001, {32'hE1,32'hD6,32'hD5,32'hD4}, 4'b1111);
        vecs[18] = mk(4'b0000, 28'h0, 128'h0,
                      2'b01, {7'd30,7'd42}, {32'hD4,32'hE2}, 4'b1000, {32'hE2,32'hD6,32'hD5,32'hD4}, 4'b1111);
        vecs[19] = mk(4'b0000, 28'h0, 128'h0,
                      2'b00, {7'd30,7'd42}, {32'hD4,32'hE2}, 4'b0000, {32'hE2,32'hD6,32'hD5,32'hD4}, 4'b1111);

        rst_n = 1'b0;
        setIdle();
        #2;
        checkOutput("reset_rdy", 32'(eu_rdy), 32'h0);
        checkOutput("reset_en", 32'(wr_en), 32'h0);
        checkOutput("reset_rvld", 32'(reg_vld), 32'h0);
        checkOutput("reset_pdata0", wr_data[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_rdy", 32'(eu_rdy), 32'hF);

        for (int r = 0; r < 20; r++) begin
            applyStimulus(vecs[r]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_en", r), 32'(wr_en), 32'(vecs[r].en));
            checkOutput($sformatf("v%0d_rvld", r), 32'(reg_vld), 32'(vecs[r].rvld));
            checkOutput($sformatf("v%0d_rdy", r), 32'(eu_rdy), 32'(vecs[r].rdy));
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("v%0d_pidx%0d", r, p), 32'(wr_idx[p]), 32'(vecs[r].pidx[p]));
                checkOutput($sformatf("v%0d_pdata%0d", r, p), wr_data[p], vecs[r].pdata[p]);
            end
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("v%0d_rdata%0d", r, i), reg_data[i], vecs[r].rdata[i]);
            end
        end

        // Reset mid-flight: EU2 and EU3 are full, EU0 and EU1 hold one entry each.
        eu_vld = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            eu_idx[i]  = 7'(50 + i);
            eu_data[i] = 32'hF0 + 32'(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            eu_data[i] = 32'hF4 + 32'(i);
        end
        @(posedge clk);
        #1;
        setIdle();
        checkOutput("mid_rdy_full", 32'(eu_rdy), 32'h3);
        checkOutput("mid_en", 32'(wr_en), 32'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_en", 32'(wr_en), 32'h0);
        checkOutput("mid_reset_rvld", 32'(reg_vld), 32'h0);
        checkOutput("mid_reset_rdy", 32'(eu_rdy), 32'h0);
        checkOutput("mid_reset_pidx0", 32'(wr_idx[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_release_rdy", 32'(eu_rdy), 32'hF);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stale_en%0d", c), 32'(wr_en), 32'h0);
            checkOutput($sformatf("stale_rvld%0d", c), 32'(reg_vld), 32'h0);
        end

        // Random soak followed by a drain; every accepted result must appear once.
        for (int i = 0; i < 4; i++) begin
            occ[i]   = 0;
            waits[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            soakCycle(1'b1);
        end
        for (int c = 0; c < 8; c++) begin
            soakCycle(1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_left%0d", i), 32'(expq[i].size()), 32'h0);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
